// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency RAM between the fetch (I) and load/store (D) ports.
// Build macro ARB_ROUND_ROBIN_EN selects a round-robin tie-break; when it is undefined, D has fixed priority over I.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NBE = 4
) (
    input  logic           clk,
    input  logic           reset,

    input  logic           i_req,
    input  logic [AW-1:0]  i_addr,
    output logic           i_gnt,
    output logic           i_rvalid,
    output logic [DW-1:0]  i_rdata,

    input  logic           d_req,
    input  logic           d_we,
    input  logic [AW-1:0]  d_addr,
    input  logic [DW-1:0]  d_wdata,
    input  logic [NBE-1:0] d_amp,
    output logic           d_gnt,
    output logic           d_rvalid,
    output logic [DW-1:0]  d_rdata,

    output logic           m_req,
    output logic           m_we,
    output logic [AW-1:0]  m_addr,
    output logic [DW-1:0]  m_wdata,
    output logic [NBE-1:0] m_be,
    input  logic           m_ack,
    input  logic [DW-1:0]  m_rdata,

    output logic           busy
);

    // state  | meaning
    // IDLE   | no transaction outstanding; grants allowed
    // BUSY_I | fetch request on the memory bus, waiting for m_ack
    // BUSY_D | load/store request on the memory bus, waiting for m_ack
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t         state_q;
    logic           last_d_q;
    logic           store_q;
    logic           m_req_q;
    logic           m_we_q;
    logic [AW-1:0]  m_addr_q;
    logic [DW-1:0]  m_wdata_q;
    logic [NBE-1:0] m_be_q;
    logic           i_rvalid_q;
    logic           d_rvalid_q;
    logic [DW-1:0]  i_rdata_q;
    logic [DW-1:0]  d_rdata_q;

    logic           m_we_d;
    logic [AW-1:0]  m_addr_d;
    logic [DW-1:0]  m_wdata_d;
    logic [NBE-1:0] m_be_d;

    logic           can_grant;
    logic           pick_d;
    logic           i_gnt_c;
    logic           d_gnt_c;

    // Grants are gated by reset so that every output reads 0 while reset is held.
    assign can_grant = (state_q == IDLE) && reset;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick_d = d_req && (!i_req || !last_d_q);
`else
    assign pick_d = d_req;
`endif

    assign d_gnt_c = can_grant && pick_d;
    assign i_gnt_c = can_grant && i_req && !pick_d;

    always_comb begin
        m_we_d    = 1'b0;
        m_addr_d  = {i_addr[AW-1:2], 2'b00};
        m_wdata_d = '0;
        m_be_d    = {NBE{1'b1}};
        if (pick_d) begin
            m_we_d    = d_we;
            m_addr_d  = {d_addr[AW-1:2], 2'b00};
            m_wdata_d = d_we ? d_wdata : '0;
            m_be_d    = d_we ? d_amp : {NBE{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            store_q    <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_gnt_c || i_gnt_c) begin
                        state_q   <= d_gnt_c ? BUSY_D : BUSY_I;
                        last_d_q  <= d_gnt_c;
                        store_q   <= d_gnt_c && d_we;
                        m_req_q   <= 1'b1;
                        m_we_q    <= m_we_d;
                        m_addr_q  <= m_addr_d;
                        m_wdata_q <= m_wdata_d;
                        m_be_q    <= m_be_d;
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        state_q    <= IDLE;
                        m_req_q    <= 1'b0;
                        m_we_q     <= 1'b0;
                        i_rvalid_q <= 1'b1;
                        i_rdata_q  <= m_rdata;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        state_q    <= IDLE;
                        m_req_q    <= 1'b0;
                        m_we_q     <= 1'b0;
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= store_q ? '0 : m_rdata;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_gnt    = i_gnt_c;
    assign d_gnt    = d_gnt_c;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign busy     = (state_q != IDLE);

    // Byte offsets never reach the word-addressed RAM; the pointer is idle in the fixed-priority build.
    logic unused_sigs;
    assign unused_sigs = ^{i_addr[1:0], d_addr[1:0], last_d_q};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_amp;
    logic        m_req, m_we, m_ack, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_amp(d_amp),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transaction-level reference: one outstanding memory transaction at a time.
    bit          mb_busy, mb_port_d, mb_last_d;
    logic        mb_we;
    logic [31:0] mb_addr, mb_wdata;
    logic [3:0]  mb_be;
    bit          rv_i, rv_d;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    int          lat_cnt, next_lat, cyc;
    bit          idle_ack, fix_rd_en;
    logic [31:0] fix_rd;
    bit          last_gi, last_gd;

    task automatic model_reset();
        mb_busy = 0; mb_last_d = 0; rv_i = 0; rv_d = 0;
        exp_i_rdata = '0; exp_d_rdata = '0;
        last_gi = 0; last_gd = 0;
    endtask

    task automatic step();
        bit exp_gi, exp_gd;
        exp_gi = 0; exp_gd = 0;
        @(negedge clk);
        if (!reset) begin
            model_reset();
            check("rst_i_gnt", i_gnt, 0);     check("rst_d_gnt", d_gnt, 0);
            check("rst_i_rvalid", i_rvalid, 0); check("rst_d_rvalid", d_rvalid, 0);
            check("rst_i_rdata", i_rdata, 0); check("rst_d_rdata", d_rdata, 0);
            check("rst_m_req", m_req, 0);     check("rst_m_we", m_we, 0);
            check("rst_m_addr", m_addr, 0);   check("rst_m_wdata", m_wdata, 0);
            check("rst_m_be", m_be, 0);       check("rst_busy", busy, 0);
        end else begin
            if (!mb_busy && (i_req || d_req)) begin
                if (i_req && d_req) exp_gd = RR ? !mb_last_d : 1'b1;
                else                exp_gd = d_req;
                exp_gi = !exp_gd;
            end
            check("i_gnt", i_gnt, exp_gi);
            check("d_gnt", d_gnt, exp_gd);
            check("busy", busy, mb_busy);
            check("m_req", m_req, mb_busy);
            if (mb_busy) begin
                check("m_we", m_we, mb_we);
                check("m_addr", m_addr, mb_addr);
                check("m_be", m_be, mb_be);
                if (mb_we) check("m_wdata", m_wdata, mb_wdata);
            end
            check("i_rvalid", i_rvalid, rv_i);
            check("d_rvalid", d_rvalid, rv_d);
            check("i_rdata", i_rdata, exp_i_rdata);
            check("d_rdata", d_rdata, exp_d_rdata);
            last_gi = exp_gi; last_gd = exp_gd;
            rv_i = 0; rv_d = 0;
            if (mb_busy && m_ack) begin
                mb_busy = 0;
                if (mb_port_d) begin
                    rv_d = 1;
                    exp_d_rdata = mb_we ? 32'h0 : m_rdata;
                end else begin
                    rv_i = 1;
                    exp_i_rdata = m_rdata;
                end
            end else if (!mb_busy && (exp_gi || exp_gd)) begin
                mb_busy   = 1;
                mb_port_d = exp_gd;
                mb_last_d = exp_gd;
                mb_we     = exp_gd && d_we;
                mb_addr   = (exp_gd ? d_addr : i_addr) & 32'hFFFF_FFFC;
                mb_be     = mb_we ? d_amp : 4'hF;
                mb_wdata  = d_wdata;
                lat_cnt   = next_lat;
            end
        end
        @(posedge clk);
        #1;
        m_rdata = fix_rd_en ? fix_rd : $urandom;
        if (mb_busy) begin
            m_ack = (lat_cnt == 0);
            if (lat_cnt > 0) lat_cnt--;
        end else begin
            m_ack = idle_ack;
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    logic [3:0] order;
    int         ng, prev_cyc;

    initial begin
        reset = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_amp = 0;
        m_ack = 0; m_rdata = 0;
        idle_ack = 0; fix_rd_en = 0; fix_rd = 0; next_lat = 0; cyc = 0; lat_cnt = 0;
        model_reset();
        mb_port_d = 0; mb_we = 0; mb_addr = 0; mb_wdata = 0; mb_be = 0;
        step();
        reset = 1'b1;
        step();

        // Fetch with slow ack and fixed read data.
        i_req = 1; i_addr = 32'h0000_0016; next_lat = 2;
        fix_rd_en = 1; fix_rd = 32'h0050_0093;
        step();
        i_req = 0;
        check("t1_m_addr", m_addr, 32'h14);
        check("t1_m_be", m_be, 4'hF);
        for (int k = 0; k < 10; k++) begin
            step();
            if (i_rvalid) break;
        end
        check("t1_rvalid", i_rvalid, 1);
        check("t1_rdata", i_rdata, 32'h0050_0093);
        fix_rd_en = 0;
        drain(2);

        // Byte store.
        d_req = 1; d_we = 1; d_addr = 32'h103; d_amp = 4'b1000; d_wdata = 32'hAB00_0000; next_lat = 0;
        step();
        d_req = 0;
        check("t2_m_we", m_we, 1);
        check("t2_m_addr", m_addr, 32'h100);
        check("t2_m_be", m_be, 4'b1000);
        check("t2_m_wdata", m_wdata, 32'hAB00_0000);
        for (int k = 0; k < 10; k++) begin
            step();
            if (d_rvalid) break;
        end
        check("t2_rvalid", d_rvalid, 1);
        check("t2_rdata", d_rdata, 0);
        drain(2);

        // Contention from reset: four transactions with both ports requesting.
        do_reset();
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
        order = 0; ng = 0; next_lat = 0;
        for (int k = 0; k < 20 && ng < 4; k++) begin
            step();
            if (last_gi || last_gd) begin
                order = {order[2:0], last_gd};
                ng++;
                i_addr = i_addr + 4; d_addr = d_addr + 4;
            end
        end
        i_req = 0; d_req = 0;
        check("t3_count", ng, 4);
        check("t3_order", order, RR ? 4'b1010 : 4'b1111);
        drain(3);

        // Reset during a load; late ack after release must be ignored.
        d_req = 1; d_we = 0; d_addr = 32'h200; next_lat = 5;
        step();
        d_req = 0;
        step();
        check("t4_pre_m_req", m_req, 1);
        d_req = 1;
        do_reset();
        d_req = 0;
        check("t4_busy", busy, 0);
        check("t4_m_req", m_req, 0);
        idle_ack = 1;
        step();
        idle_ack = 0;
        step();
        check("t4_no_rvalid", d_rvalid, 0);
        d_req = 1; d_addr = 32'h300; next_lat = 1;
        step();
        check("t4_regrant", m_req, 1);
        d_req = 0;
        drain(4);

        // Ack pulses with nothing outstanding.
        idle_ack = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_i_rvalid", i_rvalid, 0);
            check("t5_d_rvalid", d_rvalid, 0);
            check("t5_busy", busy, 0);
        end

        // Back-to-back loads with ack held high.
        d_req = 1; d_we = 0; d_addr = 32'h400; next_lat = 0; ng = 0; prev_cyc = 0;
        for (int k = 0; k < 20 && ng < 4; k++) begin
            step();
            if (last_gd) begin
                if (ng > 0) check("t6_gap", cyc - prev_cyc, 2);
                prev_cyc = cyc;
                ng++;
                d_addr = d_addr + 4;
            end
        end
        d_req = 0;
        check("t6_count", ng, 4);
        idle_ack = 0;
        drain(3);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if (last_gi) i_req = 0;
            if (last_gd) d_req = 0;
            if (!i_req && $urandom_range(0, 2) != 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom;
                d_wdata = $urandom; d_amp = 4'($urandom_range(0, 15));
            end
            next_lat = $urandom_range(0, 3);
            idle_ack = ($urandom_range(0, 7) == 0);
            if (n == 700) reset = 1'b0;
            if (n == 702) reset = 1'b1;
            step();
        end
        i_req = 0; d_req = 0; idle_ack = 0;
        drain(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
